// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) definitions: framing states, codeword bit positions and syndrome.
// Positions are 0-based indices into a codeword held as cw[0]=pos1 .. cw[6]=pos7.
package ham_pkg;

  typedef enum logic [1:0] {HUNT, HI, LO} state_e;

  localparam int CW_LEN = 7;

  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D1 = 2;
  localparam int P3 = 3;
  localparam int D2 = 4;
  localparam int D3 = 5;
  localparam int D4 = 6;

  // S = {s3,s2,s1}; a non-zero value names the 1-based position in error.
  function automatic logic [2:0] syndrome(input logic [CW_LEN-1:0] cw);
    syndrome = {cw[P3] ^ cw[D2] ^ cw[D3] ^ cw[D4],
                cw[P2] ^ cw[D1] ^ cw[D3] ^ cw[D4],
                cw[P1] ^ cw[D1] ^ cw[D2] ^ cw[D4]};
  endfunction

endpackage

// File: rtl/ham74_correct.sv
// Combinational single-error correction of one Hamming(7,4) codeword.
module ham74_correct
  import ham_pkg::*;
(
  input  logic [CW_LEN-1:0] cw_i,
  output logic [3:0]        data_o,
  output logic              corr_o
);

  logic [2:0]        syn;
  logic [CW_LEN-1:0] flip;
  logic [CW_LEN-1:0] fixed;

  always_comb begin
    syn    = syndrome(cw_i);
    flip   = (syn == 3'd0) ? '0 : (CW_LEN'(1) << (syn - 3'd1));
    fixed  = cw_i ^ flip;
    data_o = {fixed[D1], fixed[D2], fixed[D3], fixed[D4]};
    corr_o = (syn != 3'd0);
  end

endmodule

// File: rtl/ham74_frame_decoder.sv
// Frames the demodulated bit stream into two Hamming(7,4) codewords per PCM byte.
// Optional corrected-codeword counter is built only when HAM_ERR_CNT_EN is defined.
module ham74_frame_decoder
  import ham_pkg::*;
#(
  parameter int ERR_CNT_W     = 16,
  parameter bit HUNT_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 sync_in,
  input  logic                 err_clr,
  output logic [7:0]           pcm_out,
  output logic                 pcm_valid,
  output logic                 err_corr,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 locked
);

  localparam state_e RST_STATE = HUNT_ON_RESET ? HUNT : HI;

  state_e            state_q;
  logic [CW_LEN-1:0] sr_q;
  logic [CW_LEN-1:0] cw;
  logic [2:0]        cnt_q;
  logic [3:0]        nib_q;
  logic              hi_corr_q;
  logic [3:0]        dec_data;
  logic              dec_corr;
  logic              cw_done;

  // Codeword as it will look once the current bit lands, so the 7th bit decodes this edge.
  always_comb begin
    cw        = sr_q;
    cw[cnt_q] = bit_in;
  end

  assign cw_done = bit_valid && !sync_in && (state_q != HUNT) && (cnt_q == 3'(CW_LEN-1));

  ham74_correct u_correct (
    .cw_i   (cw),
    .data_o (dec_data),
    .corr_o (dec_corr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RST_STATE;
      sr_q      <= '0;
      cnt_q     <= '0;
      nib_q     <= '0;
      hi_corr_q <= 1'b0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      err_corr  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      pcm_valid <= 1'b0;
      err_corr  <= 1'b0;
      if (bit_valid) begin
        if (sync_in) begin
          // Sync always restarts framing, dropping any partial frame.
          sr_q[P1] <= bit_in;
          cnt_q    <= 3'd1;
          state_q  <= HI;
          locked   <= 1'b1;
        end else if (state_q != HUNT) begin
          locked <= 1'b1;
          sr_q   <= cw;
          if (cw_done) begin
            cnt_q <= '0;
            if (state_q == HI) begin
              nib_q     <= dec_data;
              hi_corr_q <= dec_corr;
              state_q   <= LO;
            end else begin
              pcm_out   <= {nib_q, dec_data};
              pcm_valid <= 1'b1;
              err_corr  <= hi_corr_q | dec_corr;
              state_q   <= HI;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
      end
    end
  end

`ifdef HAM_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end else if (cw_done && dec_corr && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_ham74_frame_decoder.sv
// Directed bench for ham74_frame_decoder; codewords below are written pos1 (MSB) .. pos7 (LSB).
module tb_ham74_frame_decoder;

  localparam int W = 2;
`ifdef HAM_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // Hand-encoded codewords.
  localparam logic [6:0] CW_A     = 7'b1011010;
  localparam logic [6:0] CW_5     = 7'b0100101;
  localparam logic [6:0] CW_3     = 7'b1000011;
  localparam logic [6:0] CW_C     = 7'b0111100;
  localparam logic [6:0] CW_A_E5  = 7'b1011110; // pos5 flipped
  localparam logic [6:0] CW_5_E2  = 7'b0000101; // pos2 flipped

  logic         clk = 1'b0;
  logic         reset, bit_in, bit_valid, sync_in, err_clr;
  logic [7:0]   pcm_out;
  logic         pcm_valid, err_corr, locked;
  logic [W-1:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  ham74_frame_decoder #(.ERR_CNT_W(W), .HUNT_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .sync_in   (sync_in),
    .err_clr   (err_clr),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid),
    .err_corr  (err_corr),
    .err_count (err_count),
    .locked    (locked)
  );

  function automatic int cnt_add(input int a, input int n);
    if (!CNT_EN) return 0;
    return (a + n > 3) ? 3 : a + n;
  endfunction

  task automatic send_bit(input logic b, input logic s, input logic clr);
    @(negedge clk);
    bit_valid = 1'b1; bit_in = b; sync_in = s; err_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0; bit_in = 1'b0; sync_in = 1'b0; err_clr = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Sends the first nbits of {hi,lo}; early counts strobes before the 14th bit, unl counts unlocked samples.
  task automatic send_frame(input logic [6:0] hi, input logic [6:0] lo, input logic sync_first,
                            input int nbits, input int maxgap, input logic clr_last,
                            output int early, output int unl);
    logic [13:0] fr;
    fr = {hi, lo};
    early = 0; unl = 0;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0 && maxgap > 0) idle(int'($urandom_range(maxgap, 1)));
      send_bit(fr[13-i], sync_first && (i == 0), clr_last && (i == 13));
      if (i < 13 && pcm_valid) early++;
      if (!locked) unl++;
    end
  endtask

  task automatic test_reset;
    int early, unl;
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; sync_in = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({pcm_out, pcm_valid, err_corr, err_count, locked} !== '0) begin n_bad++;
      $display("FAIL reset_outputs: got %h/%b/%b/%h/%b required all zero", pcm_out, pcm_valid, err_corr, err_count, locked); end
    @(negedge clk); reset = 1'b0;
    // Hunting: unsynced bits are discarded.
    send_frame(CW_A, CW_5, 1'b0, 14, 0, 1'b0, early, unl);
    idle(1);
    n_cmp++; if (unl !== 14) begin n_bad++; $display("FAIL hunt_unlocked: got %0d unlocked samples required 14", unl); end
    n_cmp++; if (early !== 0 || pcm_valid !== 1'b0) begin n_bad++; $display("FAIL hunt_no_output: got %0d strobes required 0", early + pcm_valid); end
  endtask

  task automatic test_clean;
    int early, unl;
    send_frame(CW_A, CW_5, 1'b1, 14, 0, 1'b0, early, unl);
    n_cmp++; if (pcm_valid !== 1'b1 || early !== 0) begin n_bad++; $display("FAIL clean_valid: got %b early %0d required 1 early 0", pcm_valid, early); end
    n_cmp++; if (pcm_out !== 8'hA5) begin n_bad++; $display("FAIL clean_pcm: got %h required a5", pcm_out); end
    n_cmp++; if (err_corr !== 1'b0 || err_count !== W'(exp_cnt)) begin n_bad++;
      $display("FAIL clean_err: got corr %b cnt %0d required 0 %0d", err_corr, err_count, exp_cnt); end
    n_cmp++; if (locked !== 1'b1 || unl !== 0) begin n_bad++; $display("FAIL clean_locked: got %b unl %0d required 1 0", locked, unl); end
    idle(1);
    n_cmp++; if (pcm_valid !== 1'b0) begin n_bad++; $display("FAIL clean_strobe_width: got %b required 0", pcm_valid); end
  endtask

  task automatic test_single_err;
    int early, unl;
    send_frame(CW_A_E5, CW_5, 1'b1, 14, 0, 1'b0, early, unl);
    exp_cnt = cnt_add(exp_cnt, 1);
    n_cmp++; if (pcm_valid !== 1'b1 || pcm_out !== 8'hA5 || err_corr !== 1'b1) begin n_bad++;
      $display("FAIL err_hi: got v%b %h corr %b required v1 a5 corr 1", pcm_valid, pcm_out, err_corr); end
    n_cmp++; if (err_count !== W'(exp_cnt)) begin n_bad++; $display("FAIL err_hi_cnt: got %0d required %0d", err_count, exp_cnt); end
    idle(2);
    send_frame(CW_A, CW_5_E2, 1'b1, 14, 0, 1'b0, early, unl);
    exp_cnt = cnt_add(exp_cnt, 1);
    n_cmp++; if (pcm_valid !== 1'b1 || pcm_out !== 8'hA5 || err_corr !== 1'b1) begin n_bad++;
      $display("FAIL err_lo: got v%b %h corr %b required v1 a5 corr 1", pcm_valid, pcm_out, err_corr); end
    n_cmp++; if (err_count !== W'(exp_cnt)) begin n_bad++; $display("FAIL err_lo_cnt: got %0d required %0d", err_count, exp_cnt); end
    idle(1);
  endtask

  task automatic test_gapped;
    int early, unl;
    send_frame(CW_A, CW_5, 1'b1, 14, 3, 1'b0, early, unl);
    n_cmp++; if (pcm_valid !== 1'b1 || early !== 0 || pcm_out !== 8'hA5 || err_corr !== 1'b0) begin n_bad++;
      $display("FAIL gap_frame: got v%b early %0d %h corr %b required v1 0 a5 0", pcm_valid, early, pcm_out, err_corr); end
    idle(1);
    n_cmp++; if (pcm_valid !== 1'b0) begin n_bad++; $display("FAIL gap_strobe_width: got %b required 0", pcm_valid); end
  endtask

  task automatic test_resync;
    int early, unl, e2, u2;
    send_frame(CW_A, CW_5, 1'b1, 9, 0, 1'b0, early, unl);
    send_frame(CW_3, CW_C, 1'b1, 14, 0, 1'b0, e2, u2);
    n_cmp++; if (early + e2 !== 0) begin n_bad++; $display("FAIL resync_partial: got %0d strobes required 0", early + e2); end
    n_cmp++; if (pcm_valid !== 1'b1 || pcm_out !== 8'h3C) begin n_bad++; $display("FAIL resync_pcm: got v%b %h required v1 3c", pcm_valid, pcm_out); end
    n_cmp++; if (unl + u2 !== 0) begin n_bad++; $display("FAIL resync_locked: got %0d unlocked samples required 0", unl + u2); end
    // Sync arriving where the 14th bit would have been.
    send_frame(CW_3, CW_C, 1'b1, 13, 0, 1'b0, early, unl);
    send_frame(CW_5, CW_A, 1'b1, 14, 0, 1'b0, e2, u2);
    n_cmp++; if (early + e2 !== 0 || pcm_out !== 8'h5A || pcm_valid !== 1'b1) begin n_bad++;
      $display("FAIL resync_bit14: got early %0d v%b %h required 0 v1 5a", early + e2, pcm_valid, pcm_out); end
    n_cmp++; if (err_count !== W'(exp_cnt)) begin n_bad++; $display("FAIL resync_cnt: got %0d required %0d", err_count, exp_cnt); end
    idle(1);
  endtask

  task automatic test_back_to_back;
    int early, unl;
    send_frame(CW_A, CW_5, 1'b1, 14, 0, 1'b0, early, unl);
    n_cmp++; if (pcm_valid !== 1'b1 || pcm_out !== 8'hA5) begin n_bad++; $display("FAIL b2b_first: got v%b %h required v1 a5", pcm_valid, pcm_out); end
    send_frame(CW_3, CW_C, 1'b0, 14, 0, 1'b0, early, unl);
    n_cmp++; if (pcm_valid !== 1'b1 || pcm_out !== 8'h3C || early !== 0) begin n_bad++;
      $display("FAIL b2b_second: got v%b %h early %0d required v1 3c 0", pcm_valid, pcm_out, early); end
    idle(1);
  endtask

  task automatic test_reset_mid;
    int early, unl;
    send_frame(CW_A, CW_5, 1'b1, 10, 0, 1'b0, early, unl);
    @(negedge clk);
    bit_valid = 1'b0; sync_in = 1'b0; reset = 1'b1;
    #1;
    n_cmp++; if ({pcm_out, pcm_valid, err_corr, err_count, locked} !== '0) begin n_bad++;
      $display("FAIL rstmid_async: got %h/%b/%b/%h/%b required all zero", pcm_out, pcm_valid, err_corr, err_count, locked); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({pcm_out, pcm_valid, err_corr, err_count, locked} !== '0) begin n_bad++;
      $display("FAIL rstmid_held: got %h/%b/%b/%h/%b required all zero", pcm_out, pcm_valid, err_corr, err_count, locked); end
    @(negedge clk); reset = 1'b0;
    exp_cnt = 0;
    send_frame(CW_5, CW_A, 1'b0, 4, 0, 1'b0, early, unl);
    n_cmp++; if (unl !== 4) begin n_bad++; $display("FAIL rstmid_hunt: got %0d unlocked samples required 4", unl); end
    send_frame(CW_5, CW_A, 1'b1, 14, 0, 1'b0, early, unl);
    n_cmp++; if (pcm_valid !== 1'b1 || pcm_out !== 8'h5A || err_count !== W'(exp_cnt) || early !== 0) begin n_bad++;
      $display("FAIL rstmid_frame: got v%b %h cnt %0d required v1 5a cnt %0d", pcm_valid, pcm_out, err_count, exp_cnt); end
    idle(1);
  endtask

  task automatic test_counter;
    int early, unl;
    send_frame(CW_A_E5, CW_5_E2, 1'b1, 14, 0, 1'b0, early, unl);
    exp_cnt = cnt_add(exp_cnt, 2);
    n_cmp++; if (err_count !== W'(exp_cnt) || err_corr !== 1'b1 || pcm_out !== 8'hA5) begin n_bad++;
      $display("FAIL cnt_double: got cnt %0d corr %b %h required %0d 1 a5", err_count, err_corr, pcm_out, exp_cnt); end
    for (int k = 0; k < 4; k++) begin
      send_frame(CW_A_E5, CW_5, 1'b1, 14, 0, 1'b0, early, unl);
      exp_cnt = cnt_add(exp_cnt, 1);
      n_cmp++; if (err_count !== W'(exp_cnt)) begin n_bad++; $display("FAIL cnt_sat_%0d: got %0d required %0d", k, err_count, exp_cnt); end
    end
    // Clear lands on the same edge as a corrected low-nibble decode.
    send_frame(CW_A, CW_5_E2, 1'b1, 14, 0, 1'b1, early, unl);
    exp_cnt = 0;
    n_cmp++; if (err_count !== W'(exp_cnt) || err_corr !== 1'b1) begin n_bad++;
      $display("FAIL cnt_clr: got cnt %0d corr %b required %0d 1", err_count, err_corr, exp_cnt); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_err();
    test_gapped();
    test_resync();
    test_back_to_back();
    test_reset_mid();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ham74_frame_decoder.md
Name: ham74_frame_decoder

Overview:
- Receive stage that sits directly upstream of the PCM output register in `top`.
- Takes the serial bit stream recovered by the FSK demodulator and frames it into 7-bit Hamming(7,4) codewords.
- Corrects single-bit errors in each codeword and packs two decoded nibbles into one 8-bit PCM sample, presented with a one-cycle valid strobe.

Parameters:
- ERR_CNT_W, 16, width of the corrected-error counter; saturates, does not wrap.
- HUNT_ON_RESET, 1, 1: ignore bits until the first sync_in; 0: start framing immediately at the first bit_valid after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- bit_in  input  1  demodulated data bit.
- bit_valid  input  1  bit_in is sampled on this edge when high.
- sync_in  input  1  qualified by bit_valid; marks bit_in as codeword position 1 of a new high nibble.
- err_clr  input  1  synchronous clear of err_count.
- pcm_out  output  8  decoded PCM sample.
- pcm_valid  output  1  one-cycle strobe; pcm_out is new.
- err_corr  output  1  one-cycle strobe with pcm_valid; at least one nibble of this sample was corrected.
- err_count  output  ERR_CNT_W  count of corrected codewords.
- locked  output  1  high while framing is aligned (state HI or LO).

Behaviour:
- Reset, asynchronous: pcm_out=0, pcm_valid=0, err_corr=0, err_count=0, locked=0, shift register=0, bit counter=0, nibble register=0. State = HUNT if HUNT_ON_RESET=1, else HI.
- Codeword order, serial, first bit first: pos1=p1, pos2=p2, pos3=d1, pos4=p3, pos5=d2, pos6=d3, pos7=d4.
- Nibble = {d1,d2,d3,d4}, d1 is the MSB. The first codeword of a frame is pcm_out[7:4], the second is pcm_out[3:0].
- Syndrome: s1=^{pos1,3,5,7}, s2=^{pos2,3,6,7}, s3=^{pos4,5,6,7}; S={s3,s2,s1}.
  - S!=0: invert position S before extracting data; mark the codeword corrected.
  - Double errors are miscorrected silently; this is accepted.
- States:
  - HUNT: bit_valid with sync_in → load bit as pos1, bit counter=1, go to HI. All other bits are discarded.
  - HI: collect 7 bits. On the 7th, decode → nibble register, latch the corrected flag, counter=0, go to LO.
  - LO: collect 7 bits. On the 7th, decode the low nibble. On the next edge: pcm_out={hi,lo}, pcm_valid=1, err_corr=hi_flag|lo_flag. Go to HI.
- Latency: pcm_valid is high exactly one cycle, in the cycle after the edge that samples the 14th bit.
- Cycles with bit_valid=0 leave all state unchanged. Gaps between bits are allowed in any state.
- sync_in with bit_valid in HI or LO: abandon the partial frame, with no pcm_valid and no counter update. Treat the bit as pos1 of a new high nibble (state HI, counter=1). This holds even on what would have been the 14th bit.
- err_count increments by the number of corrected codewords (0, 1 or 2), applied at the nibble decode. It saturates at all-ones.
- err_clr has priority over a same-cycle increment.
- A back-to-back bit_valid immediately after the 14th bit is accepted as pos1 of the next frame, with no dead cycle.
- Reset asserted mid-frame: immediate return to the reset values; the partial frame is lost.

Optional Feature:
- Macro: HAM_ERR_CNT_EN.
- Defined: err_count and err_clr behave as above.
- Undefined: no counter logic is built; err_count is tied to 0 and err_clr is ignored. err_corr is still produced.

Decomposition:
- ham_pkg holds:
  - the state enum {HUNT, HI, LO};
  - CW_LEN=7;
  - the position constants P1..D4;
  - a syndrome function.
- One sub-module, ham74_correct: purely combinational. Input 7-bit codeword; outputs 4-bit data and a corrected flag. The frame decoder instantiates it once, shared by HI and LO.

Test Plan:
- Clean frame: sync on the first bit, stream 1011010 then 0100101 → one pcm_valid, pcm_out=0xA5, err_corr=0, err_count=0.
- Single error in the high codeword: flip pos5 (1011110 0100101) → pcm_out=0xA5, err_corr=1, err_count=1. Also flip pos2 of the low codeword in the next frame → 0xA5, err_count=2.
- Gapped input: the same 0xA5 frame with bit_valid low 1-3 random cycles between bits → identical result; pcm_valid exactly one cycle after the 14th valid bit.
- Resync: 9 bits of a frame, then sync_in on a new frame encoding 0x3C → no output for the partial frame, then pcm_out=0x3C. locked stays 1 throughout.
- Reset mid-frame: assert reset after 10 bits, release, then send a full 0x5A frame with sync. Expect all outputs 0 while reset is held, locked=0 until the sync, then 0x5A.
- Counter: with HAM_ERR_CNT_EN and ERR_CNT_W=2, send 5 corrected frames → err_count saturates at 3. Then err_clr together with another corrected frame → 0. Without the macro, err_count stays 0.
